// File: rtl/audio_fifo_pkg.sv
// ============================================================================
// Module      : audio_fifo_pkg
// Description : Shared sample/state types and helpers for the audio output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package audio_fifo_pkg;

   localparam int c_SAMPLE_W = 16;

   typedef logic signed [c_SAMPLE_W-1:0] sample_t;

   typedef enum logic {
      PRIME = 1'b0,
      RUN   = 1'b1
   } fifo_state_t;

   localparam logic [15:0] c_STAT_MAX = 16'hFFFF;

   // Saturating event counter step used by the optional statistics outputs.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
      return (en && (v != c_STAT_MAX)) ? v + 16'd1 : v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/audio_fifo_ram.sv
// ============================================================================
// Module      : audio_fifo_ram
// Description : DEPTH x 16 simple dual-port storage, synchronous write and
//               asynchronous read; contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_fifo_ram
   import audio_fifo_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [15:0]   i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [15:0]   o_rdata
);

   sample_t r_mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= sample_t'(i_wdata);
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/audio_output_fifo.sv
// ============================================================================
// Module      : audio_output_fifo
// Description : Priming audio sample FIFO with overflow/underrun pulses.
//               Optional AUDIO_FIFO_STATS_EN adds saturating event counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_output_fifo
   import audio_fifo_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int PRIME_LEVEL = 4
) (
   input  logic                     clk,
   input  logic                     I_RSTn,
   input  logic                     audio_clk_en,
   input  logic [15:0]              in,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [15:0]              out,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic                     underrun
`ifdef AUDIO_FIFO_STATS_EN
   ,
   output logic [15:0]              overflow_count,
   output logic [15:0]              underrun_count
`endif
);

   localparam int              c_AW        = $clog2(DEPTH);
   localparam logic [c_AW:0]   c_PTR_ONE   = (c_AW+1)'(1);
   localparam logic [c_AW:0]   c_PRIME_LVL = (c_AW+1)'(PRIME_LEVEL);

   fifo_state_t     r_state;
   fifo_state_t     w_state_next;
   logic [c_AW:0]   r_wptr;
   logic [c_AW:0]   r_rptr;
   sample_t         r_last;
   logic            r_overflow;
   logic            r_underrun;

   logic            w_full;
   logic            w_pop;
   logic            w_we;
   logic            w_ovf_evt;
   logic            w_und_evt;
   logic            w_level_zero;
   logic [15:0]     w_head;

   // Full when the pointers address the same slot but differ in the wrap bit.
   assign w_full       = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                         (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
   assign level        = r_wptr - r_rptr;
   assign w_level_zero = (level == '0);

   assign out_valid = (r_state == RUN) && !w_level_zero;
   assign w_pop     = out_valid && out_ready;
   assign w_we      = audio_clk_en && (!w_full || w_pop);
   assign w_ovf_evt = audio_clk_en && w_full && !w_pop;

   assign out = out_valid ? w_head : r_last;

   always_comb begin
      w_state_next = r_state;
      w_und_evt    = 1'b0;
      case (r_state)
         PRIME: begin
            if (level >= c_PRIME_LVL) begin
               w_state_next = RUN;
            end
         end
         RUN: begin
            if (w_level_zero && out_ready) begin
               w_state_next = PRIME;
               w_und_evt    = 1'b1;
            end
         end
         default: w_state_next = PRIME;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!I_RSTn) begin
         r_state <= PRIME;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!I_RSTn) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_last     <= '0;
         r_overflow <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         if (w_we) begin
            r_wptr <= r_wptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + c_PTR_ONE;
            r_last <= sample_t'(w_head);
         end
         r_overflow <= w_ovf_evt;
         r_underrun <= w_und_evt;
      end
   end

   assign overflow = r_overflow;
   assign underrun = r_underrun;

   audio_fifo_ram #(
      .DEPTH (DEPTH),
      .AW    (c_AW)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_we && I_RSTn),
      .i_waddr (r_wptr[c_AW-1:0]),
      .i_wdata (in),
      .i_raddr (r_rptr[c_AW-1:0]),
      .o_rdata (w_head)
   );

`ifdef AUDIO_FIFO_STATS_EN
   logic [15:0] r_ovf_cnt;
   logic [15:0] r_und_cnt;

   always_ff @(posedge clk) begin
      if (!I_RSTn) begin
         r_ovf_cnt <= '0;
         r_und_cnt <= '0;
      end else begin
         r_ovf_cnt <= sat_inc16(r_ovf_cnt, r_overflow);
         r_und_cnt <= sat_inc16(r_und_cnt, r_underrun);
      end
   end

   assign overflow_count = r_ovf_cnt;
   assign underrun_count = r_und_cnt;
`endif

endmodule

`default_nettype wire
